// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C target: START/STOP/address decode, write capture, read return on open-drain SDA
// Optional read-underrun clock stretching: define I2C_SLAVE_STRETCH_EN.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
  input  logic       i2c_clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic       start,
  output logic       stop,
  output logic [7:0] data_slave_read,
  output logic       data_slave_read_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ack,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_BYTE   = 3'd3,
    WR_ACK    = 3'd4,
    RD_BYTE   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  state_t                 state;
  logic [3:0]             bit_cnt;
  logic [7:0]             rx_shreg;
  logic [7:0]             tx_shreg;
  logic                   rw;
  logic                   wr_pending;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   cond_ok;
  logic                   start_det;
  logic                   stop_det;
  logic                   load_point;
  logic                   load_now;

  // Lines idle high, so the chains reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge i2c_clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;

  // Own SDA drive only moves with SCL low, so masking while driving costs nothing.
  assign cond_ok   = ~sda_oe & scl_s & scl_d;
  assign start_det = cond_ok & sda_d & ~sda_s;
  assign stop_det  = cond_ok & ~sda_d & sda_s;

  assign load_point = scl_fall & ((state == ADDR_ACK && rw) || state == RD_ACK);

`ifdef I2C_SLAVE_STRETCH_EN
  logic load_pending;
  assign load_now = load_point | load_pending;
`else
  logic [7:0] next_byte;
  assign next_byte = tx_valid ? tx_data : IDLE_FILL;
  assign load_now  = load_point;
  assign scl_oe    = 1'b0;
`endif

  always_ff @(posedge i2c_clk) begin
    if (reset) begin
      state                 <= IDLE;
      bit_cnt               <= '0;
      rx_shreg              <= '0;
      tx_shreg              <= '0;
      rw                    <= 1'b0;
      wr_pending            <= 1'b0;
      sda_oe                <= 1'b0;
      start                 <= 1'b0;
      stop                  <= 1'b0;
      data_slave_read       <= '0;
      data_slave_read_valid <= 1'b0;
      tx_ack                <= 1'b0;
      busy                  <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_oe                <= 1'b0;
      load_pending          <= 1'b0;
`endif
    end else begin
      start                 <= 1'b0;
      stop                  <= 1'b0;
      tx_ack                <= 1'b0;
      data_slave_read_valid <= wr_pending;
      wr_pending            <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      // SCL is let go one cycle after the late load, giving SDA setup time.
      if (scl_oe && !load_pending) scl_oe <= 1'b0;
`endif
      if (start_det || stop_det) begin
        start   <= start_det;
        stop    <= stop_det;
        state   <= start_det ? ADDR : IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        scl_oe       <= 1'b0;
        load_pending <= 1'b0;
`endif
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              rx_shreg <= {rx_shreg[6:0], sda_s};
              bit_cnt  <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (rx_shreg[7:1] == SLAVE_ADDR) begin
                sda_oe <= 1'b1;
                rw     <= rx_shreg[0];
                busy   <= 1'b1;
                state  <= ADDR_ACK;
              end else begin
                state <= IDLE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              if (!rw) state <= WR_BYTE;
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              rx_shreg <= {rx_shreg[6:0], sda_s};
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                data_slave_read <= {rx_shreg[6:0], sda_s};
                wr_pending      <= 1'b1;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe  <= 1'b1;
              bit_cnt <= '0;
              state   <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WR_BYTE;
            end
          end
          RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= RD_ACK;
              end else begin
                sda_oe   <= ~tx_shreg[6];
                tx_shreg <= {tx_shreg[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_s) begin
              state <= WAIT_STOP;
              busy  <= 1'b0;
            end
          end
          default: begin
          end
        endcase

        if (load_now) begin
`ifdef I2C_SLAVE_STRETCH_EN
          if (tx_valid) begin
            tx_shreg     <= tx_data;
            tx_ack       <= 1'b1;
            sda_oe       <= ~tx_data[7];
            bit_cnt      <= 4'd1;
            state        <= RD_BYTE;
            load_pending <= 1'b0;
          end else begin
            scl_oe       <= 1'b1;
            load_pending <= 1'b1;
          end
`else
          tx_shreg <= next_byte;
          tx_ack   <= tx_valid;
          sda_oe   <= ~next_byte[7];
          bit_cnt  <= 4'd1;
          state    <= RD_BYTE;
`endif
        end
      end
    end
  end

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (responder) for the far end of the bus driven by the team's APB I2C master; replaces the behavioural slave model in the UVM bench.
- Runs on the oversampling clock i2c_clk and samples SCL/SDA through synchronizers.
- Decodes START, STOP and the 7-bit address, then either accepts write bytes or returns read bytes, driving SDA open-drain.
- Reports received data with the same strobe names the bench interface already carries.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this target answers to
SYNC_STAGES, 2, synchronizer depth on scl_i/sda_i (minimum 2)
IDLE_FILL, 8'hFF, byte returned when a read byte is needed and tx_valid is low

Ports:
i2c_clk  input  1  oversampling clock; SCL high and low phases each last at least 4 i2c_clk cycles
reset  input  1  synchronous, active-high reset
scl_i  input  1  SCL line value
sda_i  input  1  SDA line value
sda_oe  output  1  1 = pull SDA low, 0 = release
scl_oe  output  1  1 = pull SCL low (clock stretch); constant 0 without the optional feature
start  output  1  one-cycle pulse on START or repeated START
stop  output  1  one-cycle pulse on STOP
data_slave_read  output  8  last byte written by the master to this target
data_slave_read_valid  output  1  one-cycle pulse when data_slave_read updates
tx_data  input  8  next byte to return on a read
tx_valid  input  1  tx_data holds a byte
tx_ack  output  1  one-cycle pulse when tx_data is consumed
busy  output  1  high from an address match until STOP, NACK-terminated read, or START

Behaviour:
- Reset: all outputs 0, data_slave_read = 0, FSM = IDLE. A reset mid-transfer releases SDA/SCL at the next edge and discards any partial byte.
- Line sampling: SYNC_STAGES flops, then one history flop for edge detection. Event latency is SYNC_STAGES+1 cycles after the line change.
- Conditions:
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
  - Either is legal in any state and has priority over bit processing.
- Bit timing: receive bits on SCL rising edges. Change sda_oe only in the cycle an SCL falling edge is detected. Bit order is MSB first.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
  - IDLE -START-> ADDR. START in any state -> ADDR with bit counter = 0 and start pulsed.
  - ADDR: shift 8 bits (7 address bits + R/W).
    - On a match, at the next SCL fall: sda_oe = 1, go to ADDR_ACK.
    - On a mismatch: go to IDLE with SDA released; ignore the bus until the next START.
  - ADDR_ACK: at the 9th SCL fall, release SDA.
    - W=0: go to WR_BYTE.
    - R=1: load tx_data (or IDLE_FILL if tx_valid = 0), pulse tx_ack only if tx_valid = 1, drive bit 7 (sda_oe = ~bit), go to RD_BYTE.
  - WR_BYTE: after the 8th rising edge, update data_slave_read and pulse data_slave_read_valid one cycle later. At the next fall: sda_oe = 1, go to WR_ACK. Every byte is ACKed.
  - WR_ACK: at the SCL fall, release SDA and return to WR_BYTE.
  - RD_BYTE: drive the remaining bits at each fall. After the 8th bit's fall, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA at the rising edge.
    - 0 (ACK): at the fall, load the next byte as above and go to RD_BYTE.
    - 1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: hold until STOP/START.
  - STOP in any state: pulse stop, go to IDLE, release SDA. A partial byte is discarded with no valid pulse.
- Suppress bus-condition detection while sda_oe = 1, since own drive transitions happen only with SCL low.
- busy follows the FSM (states other than IDLE/WAIT_STOP after an address match).
- The bit counter is 4 bits; values beyond 8 are not reachable.

Optional Feature:
Macro I2C_SLAVE_STRETCH_EN.
- Defined: at a read-byte load point with tx_valid = 0, assert scl_oe (hold SCL low) from the detected SCL fall until tx_valid = 1. Then load tx_data, pulse tx_ack, drive bit 7, and release scl_oe one cycle later. IDLE_FILL is never sent. STOP/START or reset clears scl_oe.
- Not defined: scl_oe is tied to 0 and IDLE_FILL is sent on underrun.

Test Plan:
- Write 0x50+W then bytes 0xA5, 0x3C, STOP -> ACK on all 3 ninth clocks; data_slave_read_valid pulses twice with 0xA5 then 0x3C; start and stop each pulse once.
- Address 0x51+W -> no ACK (SDA high at 9th clock), no data_slave_read_valid, busy stays 0 until the next START.
- Read 0x50+R with tx_valid = 1 and tx_data 0x96 then 0x0F; master ACKs then NACKs -> bus bits 0x96, 0x0F; two tx_ack pulses; WAIT_STOP then IDLE on STOP.
- Read with tx_valid = 0 -> byte 0xFF on the bus, no tx_ack; with I2C_SLAVE_STRETCH_EN, scl_oe = 1 until tx_valid is raised 50 cycles later, then 0x96 is sent.
- Write 0x50+W, 0x11, repeated START, 0x50+R -> start pulses twice; 0x11 captured; read phase entered without STOP.
- STOP after 4 data bits, and separately reset asserted mid-byte -> no data_slave_read_valid, sda_oe = 0 next cycle, FSM = IDLE.
